// File: rtl/keypad_scan.sv
// 4-row x 5-column matrix keypad scanner: walks one active-low column at a time,
// synchronizes and samples the rows, debounces whole-frame results and reports keys.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [3:0] i_row,
  output logic [4:0] o_col,
  output logic [4:0] o_key_value,
  output logic       o_key_valid,
  output logic       o_key_pressed
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [4:0]      NO_KEY   = 5'h1F;
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE);
  localparam logic [2:0]      LAST_COL = 3'd4;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       col_q, col_next;
  logic [4:0]       acc_q, cand_q, stable_q;
  logic [3:0]       cnt_q;

  logic             sample, frame_end, accept;
  logic [4:0]       col_hit, frame_val, cand_d;
  logic [3:0]       cnt_d;

  // Rows are asynchronous to i_clk; idle (pulled-up) level is all ones.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments make both flops load the old value of
      // their source on the same edge, which is what builds a two-stage chain.
      row_meta <= i_row;
      row_sync <= row_meta;
    end
  end

  assign sample    = (div_q == DIV_LAST);
  assign frame_end = sample && (col_q == LAST_COL);
  assign col_next  = (col_q == LAST_COL) ? 3'd0 : col_q + 3'd1;

  // Lowest pressed row in the current column wins; iterate downwards so row 0 lands last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    col_hit = NO_KEY;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) col_hit = 5'(r * 5) + {2'b00, col_q};
    end
    frame_val = (col_hit < acc_q) ? col_hit : acc_q;
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (frame_val != cand_q) begin
      cand_d = frame_val;
      cnt_d  = 4'd1;
    end else if (cnt_q < DEB_N) begin
      cnt_d = cnt_q + 4'd1;
    end
    accept = frame_end && (cnt_d == DEB_N) && (cand_d != stable_q);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      div_q <= '0;
      col_q <= 3'd0;
      o_col <= 5'b11110;
      acc_q <= NO_KEY;
    end else begin
      div_q <= sample ? '0 : div_q + 1'b1;
      if (sample) begin
        col_q <= col_next;
        o_col <= ~(5'b00001 << col_next);
      end
      // Accumulator restarts empty for the next frame once the last column is folded in.
      if (frame_end)   acc_q <= NO_KEY;
      else if (sample) acc_q <= frame_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cand_q        <= NO_KEY;
      cnt_q         <= 4'd0;
      stable_q      <= NO_KEY;
      o_key_value   <= NO_KEY;
      o_key_valid   <= 1'b0;
      o_key_pressed <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (frame_end) begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
      end
      if (accept) begin
        stable_q      <= cand_d;
        o_key_pressed <= (cand_d != NO_KEY);
        // A release updates the held state only; the last key index stays visible.
        if (cand_d != NO_KEY) begin
          o_key_valid <= 1'b1;
          o_key_value <= cand_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: ideal keypad model plus a frame-level
// reference that debounces on a history of whole-frame results.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 5 * SCAN_DIV;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic [3:0] i_row;
  logic [4:0] o_col, o_key_value;
  logic       o_key_valid, o_key_pressed;

  logic [19:0] keys;
  int tests, fails;
  int n;
  int strobes, model_strobes;

  int hist[$];
  int stable_m, value_m;
  bit pressed_m, valid_m;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_row        (i_row),
    .o_col        (o_col),
    .o_key_value  (o_key_value),
    .o_key_valid  (o_key_valid),
    .o_key_pressed(o_key_pressed)
  );

  always #5 i_clk = ~i_clk;

  // Ideal keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r*5+c] && !o_col[c]) i_row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_result();
    for (int i = 0; i < 20; i++)
      if (keys[i]) return i;
    return 31;
  endfunction

  task automatic model_reset();
    hist.delete();
    stable_m  = 31;
    value_m   = 31;
    pressed_m = 1'b0;
    valid_m   = 1'b0;
    n         = 0;
  endtask

  // A result is accepted once the last DEBOUNCE frames agree and differ from the held state.
  task automatic model_frame_end();
    int r;
    bit same;
    r = frame_result();
    hist.push_back(r);
    if (hist.size() > DEBOUNCE) void'(hist.pop_front());
    same = (hist.size() == DEBOUNCE);
    foreach (hist[i]) if (hist[i] != r) same = 1'b0;
    if (same && r != stable_m) begin
      stable_m = r;
      if (r != 31) begin
        valid_m = 1'b1;
        value_m = r;
        model_strobes++;
      end
    end
    pressed_m = (stable_m != 31);
  endtask

  task automatic run_cycles(input int k);
    logic [4:0] exp_col;
    for (int i = 0; i < k; i++) begin
      @(posedge i_clk);
      n++;
      valid_m = 1'b0;
      if (n % FRAME == 0) model_frame_end();
      @(negedge i_clk);
      exp_col = ~(5'b00001 << ((n / SCAN_DIV) % 5));
      check("col", o_col, exp_col);
      check("valid", o_key_valid, valid_m);
      check("value", o_key_value, value_m);
      check("pressed", o_key_pressed, pressed_m);
      if (o_key_valid) strobes++;
    end
  endtask

  task automatic run_frames(input logic [19:0] k, input int nf);
    keys = k;
    run_cycles(nf * FRAME);
  endtask

  // Called at a negedge; asserts reset immediately, releases on a later negedge.
  task automatic do_reset();
    i_rstn = 1'b0;
    #1;
    check("rst_col", o_col, 5'b11110);
    check("rst_value", o_key_value, 5'h1F);
    check("rst_valid", o_key_valid, 1'b0);
    check("rst_pressed", o_key_pressed, 1'b0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    model_reset();
    strobes       = 0;
    model_strobes = 0;
  endtask

  function automatic logic [19:0] key_bit(input int idx);
    logic [19:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    tests  = 0;
    fails  = 0;
    i_rstn = 1'b1;
    keys   = '0;
    model_reset();
    @(negedge i_clk);

    // Key 12 held from reset release: one strobe, no repeats over 10 more frames.
    do_reset();
    run_frames(key_bit(12), 13);
    check("hold12_strobes", strobes, 1);
    check("hold12_pressed", o_key_pressed, 1'b1);

    // Key 12 flickering every other frame never settles.
    do_reset();
    for (int f = 0; f < 10; f++) run_frames((f % 2 == 0) ? key_bit(12) : 20'h0, 1);
    check("flicker_strobes", strobes, 0);
    check("flicker_pressed", o_key_pressed, 1'b0);

    // Keys 13 and 7 together: lowest index wins; releasing 7 hands over to 13.
    do_reset();
    run_frames(key_bit(13) | key_bit(7), 4);
    check("multi_first", o_key_value, 5'd7);
    run_frames(key_bit(13), 4);
    check("multi_strobes", strobes, 2);
    check("multi_second", o_key_value, 5'd13);

    // Press, release, press again on key 8.
    do_reset();
    run_frames(key_bit(8), 3);
    run_frames(20'h0, 3);
    check("repress_low", o_key_pressed, 1'b0);
    check("repress_hold", o_key_value, 5'd8);
    run_frames(key_bit(8), 3);
    check("repress_strobes", strobes, 2);

    // Reset during the second debounce frame of key 14, key still held afterwards.
    do_reset();
    keys = key_bit(14);
    run_cycles(FRAME + 9);
    do_reset();
    run_frames(key_bit(14), 2);
    check("midrst_early", strobes, 0);
    run_frames(key_bit(14), 1);
    check("midrst_strobes", strobes, 1);
    check("midrst_value", o_key_value, 5'd14);

    // Idle keypad: column walk only.
    do_reset();
    run_frames(20'h0, 20);
    check("idle_strobes", strobes, 0);

    // Random segments of 0..2 keys held for 1..5 frames.
    do_reset();
    for (int s = 0; s < 30; s++) begin
      logic [19:0] k;
      int nk, nf;
      k  = '0;
      nk = $urandom_range(2, 0);
      nf = $urandom_range(5, 1);
      for (int j = 0; j < nk; j++) k[$urandom_range(19, 0)] = 1'b1;
      run_frames(k, nf);
    end
    check("rand_strobes", strobes, model_strobes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
